// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants, FSM state encoding and pixel record for pixel_writer
// Contents: canvas size defaults, framebuffer address width, IDLE/WRITE/CLEAR codes, pixel_t.
package pixel_pkg;

    localparam int unsigned CANVAS_W_DEFAULT = 160;
    localparam int unsigned CANVAS_H_DEFAULT = 120;
    localparam int unsigned ADDR_W           = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] color;
    } pixel_t;

endpackage

// File: rtl/pixel_writer_if.sv
// rtl/pixel_writer_if.sv - framebuffer write bus between pixel_writer and the framebuffer
// Signals: fb_req (write request), fb_addr (word address), fb_wdata (colour), fb_ack (accept).
// Modports: master = pixel_writer side, slave = framebuffer side.
import pixel_pkg::*;

interface pixel_writer_if;
    logic              fb_req;
    logic [ADDR_W-1:0] fb_addr;
    logic [1:0]        fb_wdata;
    logic              fb_ack;

    modport master (output fb_req, output fb_addr, output fb_wdata, input fb_ack);
    modport slave  (input fb_req, input fb_addr, input fb_wdata, output fb_ack);
endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel FIFO with simultaneous push/pop
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head, valid when !empty),
//        full, empty, count (entries held). A push while full succeeds only alongside a pop.
import pixel_pkg::*;

module pixel_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  pixel_t                   wdata,
    input  logic                     pop,
    output pixel_t                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // Pop frees the slot first, so a full FIFO can still take a pixel in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers draw-engine pixels and writes them, or a full clear, to the framebuffer
// Ports: clk, rst_n (async active-low); pix_x/pix_y/pen_color/pix_valid pixel strobe;
//        clear_start clear request; fb (pixel_writer_if.master) framebuffer write bus;
//        busy, overflow (sticky drop flag), clear_done (one-cycle pulse).
// Build option: PIXEL_WRITER_CLIP_EN discards off-canvas pixels at the input.
import pixel_pkg::*;

module pixel_writer #(
    parameter int unsigned CANVAS_W   = CANVAS_W_DEFAULT,
    parameter int unsigned CANVAS_H   = CANVAS_H_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           pix_x,
    input  logic [7:0]           pix_y,
    input  logic                 pix_valid,
    input  logic [1:0]           pen_color,
    input  logic                 clear_start,
    pixel_writer_if.master       fb,
    output logic                 busy,
    output logic                 overflow,
    output logic                 clear_done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);
    localparam logic [CNT_W-1:0]  ONE_ENTRY = CNT_W'(1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              clear_pend;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] head_addr;
    pixel_t            head;
    pixel_t            in_pix;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              in_range;
    logic              push;
    logic              pop;
    logic              drop;
    logic              last_clear_ack;

`ifdef PIXEL_WRITER_CLIP_EN
    assign in_range = (32'(pix_x) < CANVAS_W) && (32'(pix_y) < CANVAS_H);
`else
    assign in_range = 1'b1;
`endif

    assign in_pix         = '{x: pix_x, y: pix_y, color: pen_color};
    assign pop            = (state == ST_WRITE) && fb.fb_ack;
    assign push           = pix_valid && in_range && (!fifo_full || pop);
    assign drop           = pix_valid && in_range && fifo_full && !pop;
    assign last_clear_ack = (state == ST_CLEAR) && fb.fb_ack && (clr_addr == LAST_ADDR);

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_pix),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Full-width product, then truncated: off-canvas coordinates wrap into the address space.
    assign head_addr = ADDR_W'(32'(head.y) * CANVAS_W + 32'(head.x));

    // A same-cycle push is looked at so a pixel reaches fb_req the cycle after its strobe,
    // and so WRITE keeps going without an idle bubble when a new pixel replaces the last one.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clear_pend && fifo_empty)   state_nxt = ST_CLEAR;
                else if (!fifo_empty || push)   state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (pop && (fifo_count == ONE_ENTRY) && !push) state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (last_clear_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clear_pend <= 1'b0;
            clr_addr   <= '0;
            overflow   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clear_done <= last_clear_ack;
            if ((state == ST_CLEAR) && fb.fb_ack)
                clr_addr <= last_clear_ack ? '0 : clr_addr + 1'b1;
            // Requests arriving while pending or mid-clear merge into the running clear.
            if (last_clear_ack)   clear_pend <= 1'b0;
            else if (clear_start) clear_pend <= 1'b1;
            if (drop)                overflow <= 1'b1;
            else if (last_clear_ack) overflow <= 1'b0;
        end
    end

    always_comb begin
        fb.fb_req   = (state == ST_WRITE) || (state == ST_CLEAR);
        fb.fb_addr  = '0;
        fb.fb_wdata = 2'd0;
        case (state)
            ST_WRITE: begin
                fb.fb_addr  = head_addr;
                fb.fb_wdata = head.color;
            end
            ST_CLEAR: fb.fb_addr = clr_addr;
            default: ;
        endcase
    end

    assign busy = !fifo_empty || (state != ST_IDLE) || clear_pend;

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter CANVAS_W, default 160, canvas width in pixels.
REQ-002 SHALL have parameter CANVAS_H, default 120, canvas height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_x  input  8  pixel column from draw engine.
REQ-007 SHALL have port pix_y  input  8  pixel row from draw engine.
REQ-008 SHALL have port pix_valid  input  1  single-cycle strobe, pixel present.
REQ-009 SHALL have port pen_color  input  2  colour, sampled with pix_valid.
REQ-010 SHALL have port clear_start  input  1  request full-canvas clear.
REQ-011 SHALL have port fb_req  output  1  framebuffer write request.
REQ-012 SHALL have port fb_addr  output  15  framebuffer word address.
REQ-013 SHALL have port fb_wdata  output  2  framebuffer write colour.
REQ-014 SHALL have port fb_ack  input  1  framebuffer accepts current write.
REQ-015 SHALL have port busy  output  1  FIFO non-empty, write pending, clear pending or clearing.
REQ-016 SHALL have port overflow  output  1  sticky, a pixel was dropped.
REQ-017 SHALL have port clear_done  output  1  one-cycle pulse, clear finished.

Function
REQ-018 SHALL enqueue {pix_x, pix_y, pen_color} on each cycle pix_valid=1 and FIFO not full.
REQ-019 SHALL drop pix_valid when full and set overflow; full with same-cycle handshake completion accepts the pixel (pop before push).
REQ-020 SHALL compute fb_addr = pix_y*CANVAS_W + pix_x, full-width product, truncated to 15 bits.
REQ-021 SHALL use FSM states IDLE, WRITE, CLEAR.
REQ-022 IDLE: clear pending and FIFO empty -> CLEAR; else FIFO non-empty -> WRITE with head entry presented; clear takes priority only once FIFO empty.
REQ-023 WRITE: fb_req=1, fb_addr/fb_wdata held stable until cycle with fb_ack=1; that cycle pops head; next cycle WRITE with next entry if FIFO non-empty, else IDLE.
REQ-024 SHALL give latency: pixel strobed at cycle N into empty FIFO in IDLE -> fb_req=1 at N+1.
REQ-025 SHALL latch clear_start as clear pending in any state; repeated pulses while pending or clearing merge.
REQ-026 CLEAR: fb_req=1, fb_wdata=0, fb_addr from 0 to CANVAS_W*CANVAS_H-1, advancing one address per fb_ack.
REQ-027 SHALL pulse clear_done on the cycle after the last CLEAR ack, return to IDLE, and clear overflow and pending.
REQ-028 SHALL keep accepting pixels into FIFO during CLEAR; overflow rules apply.
REQ-029 fb_ack while fb_req=0 SHALL be ignored.

Reset
REQ-030 SHALL on rst_n=0 force IDLE, empty FIFO, fb_req=0, fb_addr=0, fb_wdata=0, busy=0, overflow=0, clear_done=0, clear pending=0.
REQ-031 SHALL abandon any in-flight write or clear on reset with no completion pulse.

Configuration
REQ-032 With PIXEL_WRITER_CLIP_EN defined, pixels with pix_x>=CANVAS_W or pix_y>=CANVAS_H SHALL be discarded at input, never enqueued, never setting overflow.
REQ-033 Without PIXEL_WRITER_CLIP_EN, all pixels SHALL be enqueued and addresses wrap per REQ-020.

Structure
REQ-034 SHALL place FSM state encoding, canvas default constants and address width in shared package pixel_pkg.
REQ-035 SHALL implement the buffer as sub-module pixel_fifo (sync FIFO, full/empty, simultaneous push/pop).

Verification
REQ-036 Pixel (10,5,col 2), fb_ack tied 1 -> fb_req next cycle, fb_addr=810, fb_wdata=2, one transfer.
REQ-037 Five pixels back-to-back, fb_ack held 0 -> four enqueued, fifth dropped, overflow=1; release ack -> four writes in order.
REQ-038 fb_ack delayed 3 cycles -> fb_addr/fb_wdata stable across wait, single pop.
REQ-039 clear_start with 2 queued pixels -> both written first, then 19200 zero writes addr 0..19199, clear_done one cycle after last ack, overflow cleared.
REQ-040 CLIP_EN defined, pixel (200,3) -> no fb_req, overflow=0; undefined -> fb_addr=(3*160+200) mod 32768=680.
REQ-041 Reset asserted mid-CLEAR -> all outputs to reset values immediately, no clear_done.
